// File: rtl/gregorian_calendar.sv
// Day/month/year/day-of-week counter advanced on each 23->0 hour transition, with validated overwrite.
// Build option GREGORIAN_LEAP_EN selects the full Gregorian leap rule; otherwise the Julian rule (year[1:0]==0) applies.
module gregorian_calendar #(
    parameter int YEARRES    = 12,
    parameter int YEAR_MAX   = 4095,
    parameter int RESET_YEAR = 2000,
    parameter int RESET_DOW  = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 date_ow,
    input  logic [4:0]           hour_in,
    input  logic [YEARRES+8:0]   date_in,
    input  logic [2:0]           dow_in,
    output logic [3:0]           day_1s,
    output logic [3:0]           day_10s,
    output logic [3:0]           month_1s,
    output logic [3:0]           month_10s,
    output logic [3:0]           year_1s,
    output logic [3:0]           year_10s,
    output logic [3:0]           year_100s,
    output logic [3:0]           year_1000s,
    output logic [2:0]           dow,
    output logic                 day_tick,
    output logic                 month_tick,
    output logic                 year_tick,
    output logic                 load_err
);

    localparam logic [YEARRES-1:0] YEAR_MAX_V   = YEARRES'(YEAR_MAX);
    localparam logic [YEARRES-1:0] RESET_YEAR_V = YEARRES'(RESET_YEAR);
    localparam logic [2:0]         RESET_DOW_V  = 3'(RESET_DOW);

    logic [4:0]         day_r;
    logic [3:0]         month_r;
    logic [YEARRES-1:0] year_r;
    logic [2:0]         dow_r;
    logic [4:0]         hour_q;
    logic               new_day_q;

    logic [4:0]         ow_day;
    logic [3:0]         ow_month;
    logic [YEARRES-1:0] ow_year;
    logic               ow_valid;
    logic               month_end;
    logic               year_end;
    logic [YEARRES-1:0] year_next;
    logic [2:0]         dow_next;

    function automatic logic is_leap(input logic [YEARRES-1:0] y);
        int unsigned yi;
        yi = 32'(y);
`ifdef GREGORIAN_LEAP_EN
        return ((yi % 4) == 0 && (yi % 100) != 0) || (yi % 400) == 0;
`else
        return yi[1:0] == 2'b00;
`endif
    endfunction

    function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic [YEARRES-1:0] y);
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
            4'd2:                    return is_leap(y) ? 5'd29 : 5'd28;
            default:                 return 5'd31;
        endcase
    endfunction

    // Unrolled shift-add-3: a fixed shallow adder network, no sequential stages.
    function automatic logic [7:0] bcd2(input logic [6:0] bin);
        logic [7:0] bcd;
        bcd = '0;
        for (int i = 6; i >= 0; i--) begin
            for (int d = 0; d < 2; d++)
                if (bcd[d*4 +: 4] >= 4'd5) bcd[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
            bcd = {bcd[6:0], bin[i]};
        end
        return bcd;
    endfunction

    function automatic logic [15:0] bcd4(input logic [13:0] bin);
        logic [15:0] bcd;
        bcd = '0;
        for (int i = 13; i >= 0; i--) begin
            for (int d = 0; d < 4; d++)
                if (bcd[d*4 +: 4] >= 4'd5) bcd[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
            bcd = {bcd[14:0], bin[i]};
        end
        return bcd;
    endfunction

    always_comb begin
        ow_day    = date_in[YEARRES+8:YEARRES+4];
        ow_month  = date_in[YEARRES+3:YEARRES];
        ow_year   = date_in[YEARRES-1:0];
        ow_valid  = (ow_month >= 4'd1) && (ow_month <= 4'd12) &&
                    (ow_day >= 5'd1) && (ow_day <= days_in_month(ow_month, ow_year)) &&
                    (ow_year <= YEAR_MAX_V) && (dow_in <= 3'd6);
        month_end = day_r >= days_in_month(month_r, year_r);
        year_end  = month_end && (month_r == 4'd12);
        year_next = (year_r == YEAR_MAX_V) ? '0 : year_r + YEARRES'(1);
        dow_next  = (dow_r == 3'd6) ? 3'd0 : dow_r + 3'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            day_r      <= 5'd1;
            month_r    <= 4'd1;
            year_r     <= RESET_YEAR_V;
            dow_r      <= RESET_DOW_V;
            hour_q     <= 5'd0;
            new_day_q  <= 1'b0;
            day_tick   <= 1'b0;
            month_tick <= 1'b0;
            year_tick  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            hour_q     <= hour_in;
            new_day_q  <= (hour_in == 5'd0) && (hour_q == 5'd23);
            day_tick   <= 1'b0;
            month_tick <= 1'b0;
            year_tick  <= 1'b0;
            load_err   <= 1'b0;
            // An overwrite swallows a coincident pending advance, valid or not.
            if (date_ow) begin
                if (ow_valid) begin
                    day_r   <= ow_day;
                    month_r <= ow_month;
                    year_r  <= ow_year;
                    dow_r   <= dow_in;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (new_day_q) begin
                day_tick   <= 1'b1;
                month_tick <= month_end;
                year_tick  <= year_end;
                dow_r      <= dow_next;
                if (!month_end) begin
                    day_r <= day_r + 5'd1;
                end else begin
                    day_r <= 5'd1;
                    if (!year_end) begin
                        month_r <= month_r + 4'd1;
                    end else begin
                        month_r <= 4'd1;
                        year_r  <= year_next;
                    end
                end
            end
        end
    end

    assign {day_10s, day_1s}     = bcd2(7'(day_r));
    assign {month_10s, month_1s} = bcd2(7'(month_r));
    assign {year_1000s, year_100s, year_10s, year_1s} = bcd4(14'(year_r));
    assign dow = dow_r;

endmodule

// File: tb/tb_gregorian_calendar.sv
// Bench for gregorian_calendar: directed calendar scenarios plus randomized hours/loads/resets against a date model.
module tb_gregorian_calendar;

    localparam int YEARRES  = 12;
    localparam int YEAR_MAX = 4095;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               date_ow = 1'b0;
    logic [4:0]         hour_in = '0;
    logic [YEARRES+8:0] date_in = '0;
    logic [2:0]         dow_in = '0;
    logic [3:0] day_1s, day_10s, month_1s, month_10s;
    logic [3:0] year_1s, year_10s, year_100s, year_1000s;
    logic [2:0] dow;
    logic       day_tick, month_tick, year_tick, load_err;

    gregorian_calendar #(.YEARRES(YEARRES), .YEAR_MAX(YEAR_MAX), .RESET_YEAR(2000), .RESET_DOW(6)) dut (
        .clk(clk), .rst_n(rst_n), .date_ow(date_ow), .hour_in(hour_in),
        .date_in(date_in), .dow_in(dow_in),
        .day_1s(day_1s), .day_10s(day_10s), .month_1s(month_1s), .month_10s(month_10s),
        .year_1s(year_1s), .year_10s(year_10s), .year_100s(year_100s), .year_1000s(year_1000s),
        .dow(dow), .day_tick(day_tick), .month_tick(month_tick), .year_tick(year_tick),
        .load_err(load_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: calendar date as plain integers.
    int m_day = 1, m_mon = 1, m_year = 2000, m_dow = 6, m_hq = 0;
    bit m_nd = 0, m_dt = 0, m_mt = 0, m_yt = 0, m_le = 0;

    function automatic bit leap(int y);
`ifdef GREGORIAN_LEAP_EN
        return (y % 4 == 0 && y % 100 != 0) || (y % 400 == 0);
`else
        return y % 4 == 0;
`endif
    endfunction

    function automatic int dim(int m, int y);
        int tab[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (m < 1 || m > 12) return 0;
        if (m == 2 && leap(y)) return 29;
        return tab[m-1];
    endfunction

    function automatic logic [15:0] bcd(int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic model_step();
        int d, m, y, w;
        bit nd;
        if (!rst_n) begin
            m_day = 1; m_mon = 1; m_year = 2000; m_dow = 6; m_hq = 0;
            m_nd = 0; m_dt = 0; m_mt = 0; m_yt = 0; m_le = 0;
            return;
        end
        nd = (hour_in == 0) && (m_hq == 23);
        m_hq = int'(hour_in);
        m_dt = 0; m_mt = 0; m_yt = 0; m_le = 0;
        if (date_ow) begin
            d = int'(date_in[YEARRES+8 -: 5]);
            m = int'(date_in[YEARRES+3 -: 4]);
            y = int'(date_in[YEARRES-1:0]);
            w = int'(dow_in);
            if (m >= 1 && m <= 12 && d >= 1 && d <= dim(m, y) && y <= YEAR_MAX && w <= 6) begin
                m_day = d; m_mon = m; m_year = y; m_dow = w;
            end else begin
                m_le = 1;
            end
        end else if (m_nd) begin
            m_dt = 1;
            m_dow = (m_dow + 1) % 7;
            m_day++;
            if (m_day > dim(m_mon, m_year)) begin
                m_day = 1; m_mon++; m_mt = 1;
                if (m_mon > 12) begin
                    m_mon = 1; m_yt = 1;
                    m_year = (m_year == YEAR_MAX) ? 0 : m_year + 1;
                end
            end
        end
        m_nd = nd;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_eq("day",   32'({day_10s, day_1s}), 32'(bcd(m_day)));
        check_eq("month", 32'({month_10s, month_1s}), 32'(bcd(m_mon)));
        check_eq("year",  32'({year_1000s, year_100s, year_10s, year_1s}), 32'(bcd(m_year)));
        check_eq("dow",   32'(dow), 32'(m_dow));
        check_eq("ticks", 32'({day_tick, month_tick, year_tick, load_err}), 32'({m_dt, m_mt, m_yt, m_le}));
    endtask

    task automatic hr(input int h);
        hour_in = 5'(h);
        tick();
    endtask

    task automatic load(input int d, input int m, input int y, input int w);
        date_ow = 1'b1;
        date_in = {5'(d), 4'(m), YEARRES'(y)};
        dow_in  = 3'(w);
        tick();
        date_ow = 1'b0;
    endtask

    task automatic roll();
        hr(23); hr(0); hr(0); hr(0);
    endtask

    task automatic check_date(input string tag, input logic [15:0] dm, input logic [15:0] yr, input logic [2:0] w);
        check_eq({tag, "_dm"}, 32'({day_10s, day_1s, month_10s, month_1s}), 32'(dm));
        check_eq({tag, "_yr"}, 32'({year_1000s, year_100s, year_10s, year_1s}), 32'(yr));
        check_eq({tag, "_dow"}, 32'(dow), 32'(w));
    endtask

    initial begin
        int h, d, m, y, w;
        tick(); tick();
        check_date("reset", 16'h0101, 16'h2000, 3'd6);
        rst_n = 1'b1;
        hr(22); hr(23); hr(0); hr(0);
        check_date("first_roll", 16'h0201, 16'h2000, 3'd0);
        check_eq("first_tick", 32'(day_tick), 32'd1);
        hr(0); hr(0);

        load(28, 2, 2023, 2); roll();
        load(28, 2, 2024, 3); roll(); roll();
        load(28, 2, 2100, 0); hr(23); hr(0); hr(0);
`ifdef GREGORIAN_LEAP_EN
        check_date("feb2100", 16'h0103, 16'h2100, 3'd1);
`else
        check_date("feb2100", 16'h2902, 16'h2100, 3'd1);
`endif
        hr(0);
        load(29, 2, 2000, 2);
        check_date("feb29_2000", 16'h2902, 16'h2000, 3'd2);
        load(31, 12, 2099, 4); hr(23); hr(0); hr(0);
        check_date("newyear", 16'h0101, 16'h2100, 3'd5);
        check_eq("ny_ticks", 32'({day_tick, month_tick, year_tick}), 32'd7);
        hr(0);
        load(31, 12, 4095, 1); roll();
        load(31, 4, 2024, 1); hr(0);
        load(15, 13, 2024, 1); hr(0);
        load(10, 5, 2024, 7); hr(0);
        load(31, 3, 2024, 0); hr(0);
        check_date("mar31", 16'h3103, 16'h2024, 3'd0);

        // overwrite coinciding with a pending advance, then reset in the update cycle
        hr(23); hr(0); load(30, 6, 2024, 0); hr(0); hr(0);
        hr(23); hr(0); rst_n = 1'b0; tick(); rst_n = 1'b1; hr(0);
        hr(23); hr(5); hr(0); hr(0);

        for (int i = 0; i < 500; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 3) != 0) h = (hour_in == 5'd23) ? 0 : 23;
            else h = $urandom_range(0, 23);
            hour_in = 5'(h);
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 2))
                    0: y = $urandom_range(1990, 2410);
                    1: y = $urandom_range(YEAR_MAX - 3, YEAR_MAX);
                    default: y = $urandom_range(0, 4);
                endcase
                m = $urandom_range(0, 15);
                w = $urandom_range(0, 7);
                if ($urandom_range(0, 1) == 0 && m >= 1 && m <= 12) d = dim(m, y);
                else d = $urandom_range(0, 31);
                date_ow = 1'b1;
                date_in = {5'(d), 4'(m), YEARRES'(y)};
                dow_in  = 3'(w);
            end else begin
                date_ow = 1'b0;
            end
            tick();
        end
        date_ow = 1'b0;
        rst_n = 1'b1;
        hr(0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gregorian_calendar.md
# gregorian_calendar

Parametrised successor of the day/month/year counter in the clock datapath. It sits downstream of the hour counter and advances the date on every 23→0 hour transition. Day, month and year roll over in a single cycle, the leap-year rule is configurable, and it adds a synchronous reset, a validated date overwrite, a day-of-week counter and rollover pulses. It drives the BCD display digits and any alarm/schedule logic that needs calendar events.

## Interface
- YEARRES, 12: year register width; legal range 4..14.
- YEAR_MAX, 4095: last year before wrap; must be ≤ min(2^YEARRES−1, 9999).
- RESET_YEAR, 2000: year loaded on reset.
- RESET_DOW, 6: day-of-week loaded on reset (0=Sunday … 6=Saturday); 2000-01-01 is a Saturday.
- clk, input, 1: system clock.
- rst_n, input, 1: reset. Synchronous, active-low.
- date_ow, input, 1: overwrite request, one cycle.
- hour_in, input, 5: current hour in binary, 0..23.
- date_in, input, YEARRES+9: {day[4:0], month[3:0], year[YEARRES-1:0]}.
- dow_in, input, 3: day-of-week loaded with date_in.
- day_1s, day_10s, month_1s, month_10s, output, 4 each: BCD digits of day and month.
- year_1s, year_10s, year_100s, year_1000s, output, 4 each: BCD digits of year.
- dow, output, 3: day of week, 0..6.
- day_tick, month_tick, year_tick, output, 1 each: one-cycle rollover pulses.
- load_err, output, 1: one-cycle pulse when an overwrite is rejected.

## Operation
- Internal state: binary registers day_r (1..31), month_r (1..12), year_r (0..YEAR_MAX), dow_r (0..6), hour_q, and the pending flag new_day_q.
- new_day_q is registered as (hour_in==0) & (hour_q==23). hour_q is registered from hour_in every cycle.
- Days in month:
  - 31 for months 1, 3, 5, 7, 8, 10, 12.
  - 30 for months 4, 6, 9, 11.
  - February: 29 if leap, else 28.
  - The leap predicate is set by the configuration macro.
- Advance, when new_day_q=1 and date_ow=0:
  - If day_r < days_in_month, day_r increments.
  - Otherwise day_r←1. Then, if month_r < 12, month_r increments; otherwise month_r←1 and the year advances.
  - Year advance: year_r←year_r+1, or year_r←0 when year_r==YEAR_MAX.
  - dow_r←(dow_r==6) ? 0 : dow_r+1.
  - All fields update on the same edge. There is no multi-cycle cascade.
- Overwrite, when date_ow=1:
  - The load is valid when all of these hold: 1≤month≤12; 1≤day≤days_in_month(month, year_in); year_in≤YEAR_MAX; dow_in≤6.
  - Valid: all four registers load on the next edge.
  - Invalid: registers hold and load_err=1 for one cycle.
  - Either way, a coincident new_day_q is consumed and discarded: no advance, no ticks.
- BCD outputs are a combinational binary-to-BCD conversion of the registers. Unused upper digits read 0.
- Reset (rst_n=0 at an edge), values after the edge:
  - day_r=1, month_r=1, year_r=RESET_YEAR, dow_r=RESET_DOW.
  - hour_q=0 and new_day_q=0, so there is no spurious tick after reset.
  - All tick outputs and load_err are 0.
  - Reset overrides date_ow and any pending tick.

## Timing
- If hour_in becomes 0 before edge k with hour_q==23, new_day_q=1 after edge k and the date registers update at edge k+1.
- day_tick is registered and is high for exactly the cycle after edge k+1, aligned with the new date.
- month_tick and year_tick assert in that same cycle when the month or year rolled over.
- Overwrite latency is 1 edge. load_err asserts in the cycle after the rejecting edge.
- BCD outputs are valid in the same cycle as the registers, with zero added latency. The BCD conversion must meet clk timing at YEARRES=14.
- hour_in held at 0 does not retrigger; only a 23→0 transition does.
- A non-monotonic hour_in (for example a 23→5 overwrite) produces no tick.
- If reset asserts mid-pulse, the pulse is cut on the reset edge.

## Configuration
- GREGORIAN_LEAP_EN defined: leap = (year%4==0 && year%100!=0) || year%400==0.
- GREGORIAN_LEAP_EN undefined: leap = (year[1:0]==0), i.e. the Julian rule. This is cheaper and is correct for 1901..2099.
- The macro affects both the February advance and overwrite validation.

## Test plan
- Reset → 01-01-2000, dow=6, all ticks 0. Then step hour_in 22→23→0 → 02-01-2000, dow=0, day_tick for exactly 1 cycle, landing 2 edges after hour_in=0.
- Load 28-02-2023 and roll over → 01-03-2023, day_tick=1 and month_tick=1. Load 28-02-2024 and roll over → 29-02-2024, then 01-03-2024.
- Load 28-02-2100 and roll over → 01-03-2100 with GREGORIAN_LEAP_EN; → 29-02-2100 without it. Load 29-02-2000 → accepted in both builds.
- Load 31-12-2099, dow=4, and roll over → 01-01-2100, dow=5; day_tick, month_tick and year_tick all assert in the same cycle. Load 31-12-4095 and roll over → year 0.
- Load 31-04-2024 or month 13 → load_err asserts for 1 cycle and the previous date is unchanged. Load 31-03-2024 → accepted.
- Assert date_ow in the same cycle new_day_q=1 → the loaded date appears exactly, with no advance and no tick. Assert rst_n=0 in the cycle of the update → reset values win.
